// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the dual-queue FIFO read scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_LAT   = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  localparam logic SRC_LP = 1'b0;
  localparam logic SRC_HP = 1'b1;

endpackage

// File: rtl/fifo_sched_arb.sv
// Queue pick logic with anti-starvation: strict HP priority, except for one forced LP
// grant after STARVE_LIMIT back-to-back HP grants while LP has data waiting.
module fifo_sched_arb
  import fifo_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  hp_empty,
  input  logic                                  lp_empty,
  input  logic                                  grant,
  output logic                                  pick_c,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]     starve_cnt
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic starved_c;

  // Pick is only consumed when at least one queue holds data, so the LP fallback is safe.
  always_comb begin
    starved_c = !lp_empty && (starve_cnt == CNT_W'(STARVE_LIMIT));
    pick_c    = SRC_LP;
    if (starved_c) begin
      pick_c = SRC_LP;
    end else if (!hp_empty) begin
      pick_c = SRC_HP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (pick_c == SRC_HP) begin
        if (lp_empty) begin
          starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fifo_read_scheduler.sv
// Read-side controller for the HP/LP queue pair: pops one word at a time, captures it and
// presents it downstream on valid/ready, tagged with its source queue.
module fifo_read_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  hp_empty,
  input  logic                                  lp_empty,
  input  logic [DATA_WIDTH-1:0]                 q_dout,
  output logic                                  hp_rd_en,
  output logic                                  lp_rd_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_src,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]     starve_cnt
);

  state_t                state_q, state_d;
  logic                  pick_q, pick_d;
  logic                  pick_c;
  logic                  grant_c;
  logic                  any_c;
  logic                  hp_rd_d, lp_rd_d;
  logic                  out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic                  out_src_d;

  fifo_sched_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .hp_empty   (hp_empty),
    .lp_empty   (lp_empty),
    .grant      (grant_c),
    .pick_c     (pick_c),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pick_q    <= SRC_LP;
      hp_rd_en  <= 1'b0;
      lp_rd_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_LP;
    end else begin
      state_q   <= state_d;
      pick_q    <= pick_d;
      hp_rd_en  <= hp_rd_d;
      lp_rd_en  <= lp_rd_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_src   <= out_src_d;
    end
  end

  // Next state; rd_en pulses are registered so they are high for the whole RD cycle.
  always_comb begin
    state_d     = state_q;
    pick_d      = pick_q;
    grant_c     = 1'b0;
    hp_rd_d     = 1'b0;
    lp_rd_d     = 1'b0;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_src_d   = out_src;
    any_c       = !hp_empty || !lp_empty;

    unique case (state_q)
      ST_IDLE: begin
        if (en && any_c) begin
          grant_c = 1'b1;
          pick_d  = pick_c;
          hp_rd_d = (pick_c == SRC_HP);
          lp_rd_d = (pick_c == SRC_LP);
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_LAT;
      end
      ST_LAT: begin
        out_data_d  = q_dout;
        out_src_d   = pick_q;
        out_valid_d = 1'b1;
        state_d     = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (en && any_c) begin
            grant_c = 1'b1;
            pick_d  = pick_c;
            hp_rd_d = (pick_c == SRC_HP);
            lp_rd_d = (pick_c == SRC_LP);
            state_d = ST_RD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Bench for fifo_read_scheduler: queue model with one-cycle read latency and an
// expected-output scoreboard of {src, data, starve_cnt}.
module tb_fifo_read_scheduler;

  localparam int unsigned DW = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          hp_empty;
  logic          lp_empty;
  logic [DW-1:0] q_dout;
  logic          hp_rd_en;
  logic          lp_rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic [CW-1:0] starve_cnt;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hp_q[$];
  logic [DW-1:0] lp_q[$];
  int            checks;
  int            errors;

  fifo_read_scheduler #(
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hp_empty   (hp_empty),
    .lp_empty   (lp_empty),
    .q_dout     (q_dout),
    .hp_rd_en   (hp_rd_en),
    .lp_rd_en   (lp_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_flags();
    hp_empty = (hp_q.size() == 0);
    lp_empty = (lp_q.size() == 0);
  endtask

  task automatic push_exp(input logic src, input logic [DW-1:0] data, input int cnt);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.cnt  = CW'(cnt);
    exp_q.push_back(e);
  endtask

  // One clock: sample DUT before the edge, then model queue pops #1 after it.
  task automatic step();
    logic do_hp, do_lp, acc;
    exp_t e;
    do_hp = hp_rd_en;
    do_lp = lp_rd_en;
    acc   = out_valid & out_ready;
    chk("rd_exclusive", 32'(do_hp & do_lp), 32'd0);
    if (do_hp) chk("hp_pop_nonempty", 32'(hp_q.size() != 0), 32'd1);
    if (do_lp) chk("lp_pop_nonempty", 32'(lp_q.size() != 0), 32'd1);
    if (acc) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("starve_cnt", 32'(starve_cnt), 32'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
    if (do_hp && hp_q.size() != 0) q_dout = hp_q.pop_front();
    else if (do_lp && lp_q.size() != 0) q_dout = lp_q.pop_front();
    upd_flags();
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    while (exp_q.size() > target && n < 200) begin
      step();
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'(target));
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk({tag, "_hp_rd"}, 32'(hp_rd_en), 32'd0);
      chk({tag, "_lp_rd"}, 32'(lp_rd_en), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  task automatic wait_hp_rd(input string tag);
    for (int i = 0; i < 20 && hp_rd_en !== 1'b1; i++) step();
    chk(tag, 32'(hp_rd_en), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    q_dout    = '0;

    // Reset with queues loaded; LP loaded first, HP must still go first.
    lp_q.push_back(16'hA124);
    lp_q.push_back(16'hA267);
    hp_q.push_back(16'hB1B5);
    hp_q.push_back(16'hB278);
    upd_flags();
    push_exp(1'b1, 16'hB1B5, 1);
    push_exp(1'b1, 16'hB278, 2);
    push_exp(1'b0, 16'hA124, 0);
    push_exp(1'b0, 16'hA267, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hp_rd", 32'(hp_rd_en), 32'd0);
      chk("rst_lp_rd", 32'(lp_rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_src", 32'(out_src), 32'd0);
      chk("rst_cnt", 32'(starve_cnt), 32'd0);
    end
    rst = 1'b1;
    step();
    chk("first_rd_after_rst", 32'(hp_rd_en), 32'd1);
    drain(0);
    check_idle("t2_idle", 3);

    // Starvation: four HP grants then one forced LP grant.
    en = 1'b0;
    for (int i = 0; i < 6; i++) hp_q.push_back(DW'(16'h1000 + i));
    lp_q.push_back(16'h2000);
    lp_q.push_back(16'h2001);
    upd_flags();
    push_exp(1'b1, 16'h1000, 1);
    push_exp(1'b1, 16'h1001, 2);
    push_exp(1'b1, 16'h1002, 3);
    push_exp(1'b1, 16'h1003, 4);
    push_exp(1'b0, 16'h2000, 0);
    push_exp(1'b1, 16'h1004, 1);
    push_exp(1'b1, 16'h1005, 2);
    push_exp(1'b0, 16'h2001, 0);
    en = 1'b1;
    drain(0);

    // Backpressure: held output stays stable, no pops while stalled.
    en = 1'b0;
    hp_q.push_back(16'hC000);
    hp_q.push_back(16'hC001);
    upd_flags();
    push_exp(1'b1, 16'hC000, 0);
    push_exp(1'b1, 16'hC001, 0);
    out_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) step();
    chk("t4_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_data", 32'(out_data), 32'h0000_C000);
      chk("t4_hold_src", 32'(out_src), 32'd1);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_no_rd", 32'(hp_rd_en | lp_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_next_pop", 32'(hp_rd_en), 32'd1);
    drain(0);

    // en dropped in RD: that word completes, then the scheduler parks.
    en = 1'b0;
    hp_q.push_back(16'hD000);
    hp_q.push_back(16'hD001);
    hp_q.push_back(16'hD002);
    upd_flags();
    push_exp(1'b1, 16'hD000, 0);
    push_exp(1'b1, 16'hD001, 0);
    push_exp(1'b1, 16'hD002, 0);
    en = 1'b1;
    wait_hp_rd("t5_rd");
    en = 1'b0;
    drain(2);
    check_idle("t5_parked", 3);
    chk("t5_hp_nonempty", 32'(hp_empty), 32'd0);
    en = 1'b1;
    drain(0);

    // Reset in LAT: popped word is lost and the starve count clears.
    en = 1'b0;
    hp_q.push_back(16'hE000);
    hp_q.push_back(16'hE001);
    lp_q.push_back(16'hF000);
    upd_flags();
    push_exp(1'b1, 16'hE001, 1);
    push_exp(1'b0, 16'hF000, 0);
    en = 1'b1;
    wait_hp_rd("t6_rd");
    step();
    rst = 1'b0;
    step();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_cnt", 32'(starve_cnt), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_no_rd", 32'(hp_rd_en | lp_rd_en), 32'd0);
    rst = 1'b1;
    drain(0);
    check_idle("t6_idle", 3);

    chk("queues_drained", 32'(hp_q.size() + lp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
